// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI responder.
package spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_slave_state_e;

  // Mode 0, MSB first: sample MOSI on SCLK rise, drive MISO after SCLK fall.
  localparam bit SPI_CPOL      = 1'b0;
  localparam bit SPI_CPHA      = 1'b0;
  localparam bit SPI_MSB_FIRST = 1'b1;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin with single-cycle
// rise/fall pulses derived from the synchronized value.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              dly_q;

  // Synchronizer chain plus a one-cycle delayed copy of its output.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {STAGES{RST_VAL}};
      dly_q  <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      dly_q  <= sync_q[STAGES-1];
    end
  end

  assign rise_o = sync_q[STAGES-1] & ~dly_q;
  assign fall_o = ~sync_q[STAGES-1] & dly_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder: oversampled SCLK/SS_n/MOSI, byte-wide TX holding
// buffer with valid/ready, RX word output with valid/ready and error flags.
module spi_slave
  import spi_pkg::*;
#(
  parameter int                DATA_W      = 8,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] IDLE_TX     = 8'hFF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              sclk_i,
  input  logic              ss_ni,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic              miso_oe_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic              rx_overrun_o,
  output logic              tx_underrun_o,
  output logic              busy_o,
  output logic              frame_done_o
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic sclk_rise, sclk_fall, ss_rise, ss_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk_i (clk_i), .rst_ni(rst_ni), .d_i(sclk_i),
    .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
    .clk_i (clk_i), .rst_ni(rst_ni), .d_i(ss_ni),
    .rise_o(ss_rise), .fall_o(ss_fall)
  );

  // MOSI gets the same depth as SCLK so the sampled bit lines up with the rise pulse.
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   mosi_s;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) mosi_sync_q <= '0;
    else         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
  end
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  spi_slave_state_e  state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              hold_full_q, hold_full_d;
  logic              fresh_q, fresh_d;  // current word loaded, no rise seen yet
  logic              miso_q, miso_d, miso_oe_q, miso_oe_d;
  logic              rx_valid_q, rx_valid_d, rx_ovr_q, rx_ovr_d, tx_und_q, tx_und_d;
  logic              frame_done_q, frame_done_d;
  logic [DATA_W-1:0] rx_word;
  logic              do_load;

  // State register and all datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      rx_shift_q   <= '0;
      tx_shift_q   <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      rx_data_q    <= '0;
      fresh_q      <= 1'b0;
      miso_q       <= 1'b0;
      miso_oe_q    <= 1'b0;
      rx_valid_q   <= 1'b0;
      rx_ovr_q     <= 1'b0;
      tx_und_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_shift_q   <= rx_shift_d;
      tx_shift_q   <= tx_shift_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      rx_data_q    <= rx_data_d;
      fresh_q      <= fresh_d;
      miso_q       <= miso_d;
      miso_oe_q    <= miso_oe_d;
      rx_valid_q   <= rx_valid_d;
      rx_ovr_q     <= rx_ovr_d;
      tx_und_q     <= tx_und_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next-state logic: handshakes first, then frame/bit events, then shifter load.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    rx_shift_d   = rx_shift_q;
    tx_shift_d   = tx_shift_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    rx_data_d    = rx_data_q;
    fresh_d      = fresh_q;
    miso_d       = miso_q;
    miso_oe_d    = miso_oe_q;
    rx_valid_d   = rx_valid_q;
    rx_ovr_d     = rx_ovr_q;
    tx_und_d     = tx_und_q;
    frame_done_d = 1'b0;
    do_load      = 1'b0;
    rx_word      = (rx_shift_q << 1) | DATA_W'(mosi_s);

    if (rx_valid_q && rx_ready_i) rx_valid_d = 1'b0;
    if (tx_valid_i && !hold_full_q) begin
      hold_d      = tx_data_i;
      hold_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d    = ACTIVE;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
          miso_oe_d  = 1'b1;
          rx_ovr_d   = 1'b0;
          tx_und_d   = 1'b0;
          do_load    = 1'b1;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          // SS release wins over any same-cycle SCLK edge.
          state_d      = IDLE;
          bit_cnt_d    = '0;
          rx_shift_d   = '0;
          miso_oe_d    = 1'b0;
          miso_d       = 1'b0;
          frame_done_d = 1'b1;
        end else if (sclk_rise) begin
          rx_shift_d = rx_word;
          fresh_d    = 1'b0;
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            bit_cnt_d  = '0;
            rx_data_d  = rx_word;
            rx_valid_d = 1'b1;
            if (rx_valid_q && !rx_ready_i) rx_ovr_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (sclk_fall) begin
          if (bit_cnt_q != '0) begin
            tx_shift_d = tx_shift_q << 1;
            miso_d     = tx_shift_q[DATA_W-2];
          end else if (!fresh_q) begin
            do_load = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_load) begin
      fresh_d = 1'b1;
      if (hold_full_q) begin
        tx_shift_d  = hold_q;
        hold_full_d = 1'b0;
      end else begin
        tx_shift_d = IDLE_TX;
        tx_und_d   = 1'b1;
      end
      miso_d = tx_shift_d[DATA_W-1];
    end
  end

  assign miso_o        = miso_q;
  assign miso_oe_o     = miso_oe_q;
  assign tx_ready_o    = ~hold_full_q;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign rx_overrun_o  = rx_ovr_q;
  assign tx_underrun_o = tx_und_q;
  assign busy_o        = (state_q == ACTIVE);
  assign frame_done_o  = frame_done_q;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a mode-0 SPI master drives frames, a
// transaction-level model predicts MISO bytes, RX words and flags, and a
// per-cycle process checks select/busy/frame_done against the SS pin history.
module tb_spi_slave;

  localparam int         DW        = 8;
  localparam int         SYNC      = 2;
  localparam logic [7:0] IDLE_BYTE = 8'hFF;

  logic       clk = 1'b0, rst_ni = 1'b0, sclk = 1'b0, ss_n = 1'b1, mosi = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0, rx_ready = 1'b0;
  logic       miso_o, miso_oe_o, tx_ready_o, rx_valid_o, rx_overrun_o;
  logic       tx_underrun_o, busy_o, frame_done_o;
  logic [7:0] rx_data_o;

  spi_slave #(.DATA_W(DW), .SYNC_STAGES(SYNC), .IDLE_TX(IDLE_BYTE)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .sclk_i(sclk), .ss_ni(ss_n), .mosi_i(mosi),
    .miso_o(miso_o), .miso_oe_o(miso_oe_o),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready),
    .rx_overrun_o(rx_overrun_o), .tx_underrun_o(tx_underrun_o),
    .busy_o(busy_o), .frame_done_o(frame_done_o)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Transaction-level model state.
  bit         m_hold_full;
  logic [7:0] m_hold;
  bit         m_pending;
  logic [7:0] m_rx;
  logic [7:0] mosi_words [4];
  logic [7:0] got_tx     [4];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_reset_vals"},
          {16'h0, miso_o, miso_oe_o, tx_ready_o, rx_valid_o, rx_data_o,
           rx_overrun_o, tx_underrun_o, busy_o, frame_done_o},
          32'h0000_2000);
  endtask

  task automatic model_reset();
    m_hold_full = 1'b0;
    m_hold      = 8'h00;
    m_pending   = 1'b0;
    m_rx        = 8'h00;
  endtask

  // Drive one TX handshake; called on a negedge, returns on a negedge.
  task automatic tx_push(input logic [7:0] v);
    int t;
    t        = 0;
    tx_data  = v;
    tx_valid = 1'b1;
    while (tx_ready_o !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("tx_push_ready", {31'h0, tx_ready_o}, 32'h1);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic rx_consume();
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready  = 1'b0;
    m_pending = 1'b0;
  endtask

  // Mode-0 master. The final SCLK fall coincides with the SS rise, so only
  // words that actually start get loaded. rx_ready is pulsed in the exact
  // cycle the slave completes word ready_word; a TX push happens during
  // bit 3 of word push_word.
  task automatic spi_frame(input int nrises, input int hp, input int ready_word,
                           input int push_word, input logic [7:0] push_val,
                           input bit end_reset);
    int w, b;
    for (int k = 0; k < 4; k++) got_tx[k] = 8'h00;
    @(negedge clk);
    ss_n = 1'b0;
    mosi = mosi_words[0][7];
    repeat (hp) @(negedge clk);
    for (int i = 0; i < nrises; i++) begin
      w = i / 8;
      b = i % 8;
      if (i > 0) begin
        sclk = 1'b0;
        mosi = mosi_words[w][7-b];
        repeat (hp) @(negedge clk);
      end
      got_tx[w][7-b] = miso_o;
      sclk = 1'b1;
      if (w == ready_word && b == 7) begin
        repeat (SYNC) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        repeat (hp - SYNC - 1) @(negedge clk);
      end else if (w == push_word && b == 3) begin
        tx_push(push_val);
        repeat (hp - 1) @(negedge clk);
      end else begin
        repeat (hp) @(negedge clk);
      end
    end
    if (end_reset) begin
      rst_ni = 1'b0;
      #1;
      check_reset_vals("midframe");
      sclk = 1'b0;
      ss_n = 1'b1;
      mosi = 1'b0;
      repeat (2) @(negedge clk);
      rst_ni = 1'b1;
    end else begin
      sclk = 1'b0;
      ss_n = 1'b1;
    end
  endtask

  // Predict the frame, run it, compare.
  task automatic run_frame(input string tag, input int nrises, input int hp,
                           input int ready_word, input int push_word,
                           input logic [7:0] push_val);
    int         nloads, ncomp, nb;
    logic [7:0] exp_tx [4];
    bit         e_und, e_ovr;
    nloads = (nrises + 7) / 8;
    ncomp  = nrises / 8;
    e_und  = 1'b0;
    e_ovr  = 1'b0;
    for (int w = 0; w < 4; w++) exp_tx[w] = 8'h00;
    for (int w = 0; w < nloads; w++) begin
      if (w > 0 && push_word == w - 1) begin
        m_hold_full = 1'b1;
        m_hold      = push_val;
      end
      if (m_hold_full) begin
        exp_tx[w]   = m_hold;
        m_hold_full = 1'b0;
      end else begin
        exp_tx[w] = IDLE_BYTE;
        e_und     = 1'b1;
      end
    end
    if (push_word >= 0 && push_word == nloads - 1) begin
      m_hold_full = 1'b1;
      m_hold      = push_val;
    end
    for (int w = 0; w < ncomp; w++) begin
      if (w != ready_word && m_pending) e_ovr = 1'b1;
      m_pending = 1'b1;
      m_rx      = mosi_words[w];
    end

    spi_frame(nrises, hp, ready_word, push_word, push_val, 1'b0);
    repeat (SYNC + 4) @(negedge clk);

    for (int w = 0; w < nloads; w++) begin
      nb = (nrises - 8 * w >= 8) ? 8 : nrises - 8 * w;
      check($sformatf("%s_miso_w%0d", tag, w), 32'(got_tx[w] >> (8 - nb)),
            32'(exp_tx[w] >> (8 - nb)));
    end
    check({tag, "_rx_valid"},    {31'h0, rx_valid_o},    {31'h0, m_pending});
    check({tag, "_rx_data"},     {24'h0, rx_data_o},     {24'h0, m_rx});
    check({tag, "_rx_overrun"},  {31'h0, rx_overrun_o},  {31'h0, e_ovr});
    check({tag, "_tx_underrun"}, {31'h0, tx_underrun_o}, {31'h0, e_und});
    check({tag, "_tx_ready"},    {31'h0, tx_ready_o},    {31'h0, !m_hold_full});
    $display("frame %s: rises=%0d hp=%0d miso=%h,%h,%h mosi=%h,%h,%h rx_data=%h rx_valid=%b ovr=%b und=%b",
             tag, nrises, hp, got_tx[0], got_tx[1], got_tx[2],
             mosi_words[0], mosi_words[1], mosi_words[2],
             rx_data_o, rx_valid_o, rx_overrun_o, tx_underrun_o);
  endtask

  // Per-cycle check: after posedge k the frame outputs reflect the SS pin as
  // sampled SYNC posedges earlier.
  logic [3:0] ss_hist = 4'hF;
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_ni) ss_hist = 4'hF;
      else         ss_hist = {ss_hist[2:0], ss_n};
      #1;
      if (rst_ni && chk_en) begin
        check("cyc_busy",       {31'h0, busy_o},       {31'h0, !ss_hist[SYNC]});
        check("cyc_miso_oe",    {31'h0, miso_oe_o},    {31'h0, !ss_hist[SYNC]});
        check("cyc_frame_done", {31'h0, frame_done_o},
              {31'h0, (ss_hist[SYNC] && !ss_hist[SYNC+1])});
        if (!miso_oe_o) check("cyc_miso_idle", {31'h0, miso_o}, 32'h0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run time exceeded, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    for (int k = 0; k < 4; k++) mosi_words[k] = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    rst_ni = 1'b1;
    chk_en = 1'b1;

    // 1: single word, buffered A5, master sends 3C at clk/8.
    @(negedge clk);
    tx_push(8'hA5);
    m_hold_full = 1'b1;
    m_hold      = 8'hA5;
    check("t1_tx_ready_full", {31'h0, tx_ready_o}, 32'h0);
    mosi_words[0] = 8'h3C;
    run_frame("t1", 8, 4, -1, -1, 8'h00);
    check("t1_miso_lit",  {24'h0, got_tx[0]}, 32'hA5);
    check("t1_rx_lit",    {24'h0, rx_data_o}, 32'h3C);
    check("t1_flags_lit", {30'h0, rx_overrun_o, tx_underrun_o}, 32'h0);
    rx_consume();

    // 2: two words, only 11 buffered, rx_ready held low.
    tx_push(8'h11);
    m_hold_full = 1'b1;
    m_hold      = 8'h11;
    mosi_words[0] = 8'hC3;
    mosi_words[1] = 8'h5A;
    run_frame("t2", 16, 4, -1, -1, 8'h00);
    check("t2_miso_lit", {16'h0, got_tx[0], got_tx[1]}, 32'h11FF);
    check("t2_flags_lit", {30'h0, rx_overrun_o, tx_underrun_o}, 32'h3);
    check("t2_rx_lit", {24'h0, rx_data_o}, 32'h5A);
    rx_consume();

    // 3: as 2, with rx_ready exactly in word 2's completion cycle.
    tx_push(8'h11);
    m_hold_full = 1'b1;
    m_hold      = 8'h11;
    run_frame("t3", 16, 5, 1, -1, 8'h00);
    check("t3_lit", {30'h0, rx_valid_o, rx_overrun_o}, 32'h2);
    rx_consume();

    // 4: abort after 5 rises, then a full 81 frame.
    mosi_words[0] = 8'hE7;
    run_frame("t4a", 5, 4, -1, -1, 8'h00);
    check("t4_no_valid_lit", {31'h0, rx_valid_o}, 32'h0);
    mosi_words[0] = 8'h81;
    run_frame("t4b", 8, 4, -1, -1, 8'h00);
    check("t4_rx_lit", {24'h0, rx_data_o}, 32'h81);
    rx_consume();

    // 5: reset in the middle of a word, then a clean frame.
    tx_push(8'h33);
    mosi_words[0] = 8'h5A;
    spi_frame(3, 4, -1, -1, 8'h00, 1'b1);
    model_reset();
    $display("frame t5a: reset after 3 rises");
    @(negedge clk);
    tx_push(8'h69);
    m_hold_full = 1'b1;
    m_hold      = 8'h69;
    mosi_words[0] = 8'h96;
    run_frame("t5b", 8, 4, -1, -1, 8'h00);
    check("t5_lit", {16'h0, got_tx[0], rx_data_o}, 32'h6996);
    rx_consume();

    // 6: SCLK activity while deselected.
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      sclk = ~sclk;
      mosi = 1'($urandom);
      repeat (3) @(negedge clk);
    end
    sclk = 1'b0;
    repeat (SYNC + 4) @(negedge clk);
    check("t6_lit", {29'h0, rx_valid_o, miso_oe_o, busy_o}, 32'h0);
    $display("frame t6: 12 SCLK edges with SS_n high");

    // Randomized frames.
    for (int it = 0; it < 30; it++) begin
      int         nwords, nr, hp, rw, pw;
      logic [7:0] pv;
      nwords = $urandom_range(1, 3);
      nr     = nwords * 8;
      if ($urandom_range(0, 4) == 0) nr = $urandom_range(1, nwords * 8 - 1);
      hp = $urandom_range(4, 7);
      for (int k = 0; k < 4; k++) mosi_words[k] = 8'($urandom);
      if (!m_hold_full && $urandom_range(0, 1) == 1) begin
        pv = 8'($urandom);
        tx_push(pv);
        m_hold_full = 1'b1;
        m_hold      = pv;
      end
      rw = -1;
      if (nr / 8 > 0 && $urandom_range(0, 2) == 0) rw = $urandom_range(0, nr / 8 - 1);
      pw = -1;
      if ($urandom_range(0, 1) == 1) begin
        pw = $urandom_range(0, (nr + 7) / 8 - 1);
        if (nr <= 8 * pw + 3) pw = -1;
      end
      pv = 8'($urandom);
      run_frame($sformatf("rnd%0d", it), nr, hp, rw, pw, pv);
      if ($urandom_range(0, 1) == 1) rx_consume();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
